// File: rtl/regfile_stream_reader_if.sv
// Command, register-file read port and output stream of regfile_stream_reader.
// The reader connects through the master modport; its environment uses slave.
interface regfile_stream_reader_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int INDEX_WIDTH = 2
);
    logic                   start;
    logic [INDEX_WIDTH-1:0] start_index;
    logic [INDEX_WIDTH-1:0] count;
    logic [INDEX_WIDTH-1:0] read_index;
    logic [DATA_WIDTH-1:0]  read_data;
    logic [DATA_WIDTH-1:0]  out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic                   done;
    logic [DATA_WIDTH-1:0]  checksum;

    modport master (
        input  start, start_index, count, read_data, out_ready,
        output read_index, out_data, out_valid, busy, done, checksum
    );

    modport slave (
        output start, start_index, count, read_data, out_ready,
        input  read_index, out_data, out_valid, busy, done, checksum
    );
endinterface

// File: rtl/regfile_stream_reader.sv
// Walks the register file read port from a start index, streams each word on
// a valid/ready output and finishes with a done pulse carrying a modular sum.
module regfile_stream_reader #(
    parameter int DATA_WIDTH  = 8,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                    clock,
    input  logic                    clear,
    regfile_stream_reader_if.master bus
);
    localparam int                   DEPTH    = 2 ** INDEX_WIDTH;
    localparam logic [INDEX_WIDTH:0] REM_FULL = (INDEX_WIDTH + 1)'(DEPTH);
    localparam logic [INDEX_WIDTH:0] REM_ONE  = (INDEX_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_r, state_next_s;
    logic [INDEX_WIDTH-1:0] idx_r, idx_next_s;
    logic [INDEX_WIDTH:0]   rem_r, rem_next_s;
    logic [DATA_WIDTH-1:0]  acc_r, acc_next_s;
    logic [DATA_WIDTH-1:0]  out_data_r, out_data_next_s;
    logic [DATA_WIDTH-1:0]  checksum_r, checksum_next_s;
    logic                   out_valid_r, out_valid_next_s;
    logic                   busy_r, busy_next_s;
    logic                   done_r, done_next_s;
    logic                   accept_s;

    // Index advance wraps naturally at the file depth.
    function automatic logic [INDEX_WIDTH-1:0] wrap_inc(input logic [INDEX_WIDTH-1:0] i);
        return i + INDEX_WIDTH'(1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] mod_add(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        return a + b;
    endfunction

    // Next-state and next-register values for the walk.
    always_comb begin
        state_next_s     = state_r;
        idx_next_s       = idx_r;
        rem_next_s       = rem_r;
        acc_next_s       = acc_r;
        out_data_next_s  = out_data_r;
        checksum_next_s  = checksum_r;
        out_valid_next_s = out_valid_r;
        accept_s         = out_valid_r && bus.out_ready;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    idx_next_s   = bus.start_index;
                    rem_next_s   = (bus.count == '0) ? REM_FULL : {1'b0, bus.count};
                    acc_next_s   = '0;
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                out_data_next_s  = bus.read_data;
                out_valid_next_s = 1'b1;
                state_next_s     = ST_HOLD;
            end
            ST_HOLD: begin
                if (accept_s) begin
                    acc_next_s       = mod_add(acc_r, out_data_r);
                    out_valid_next_s = 1'b0;
                    if (rem_r == REM_ONE) begin
                        checksum_next_s = mod_add(acc_r, out_data_r);
                        state_next_s    = ST_DONE;
                    end else begin
                        rem_next_s   = rem_r - REM_ONE;
                        idx_next_s   = wrap_inc(idx_r);
                        state_next_s = ST_FETCH;
                    end
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        // busy and done are registered from the state being entered.
        busy_next_s = (state_next_s != ST_IDLE);
        done_next_s = (state_next_s == ST_DONE);
    end

    // State and output registers; clear abandons any transfer at once.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            rem_r       <= '0;
            acc_r       <= '0;
            out_data_r  <= '0;
            checksum_r  <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            idx_r       <= idx_next_s;
            rem_r       <= rem_next_s;
            acc_r       <= acc_next_s;
            out_data_r  <= out_data_next_s;
            checksum_r  <= checksum_next_s;
            out_valid_r <= out_valid_next_s;
            busy_r      <= busy_next_s;
            done_r      <= done_next_s;
        end
    end

    assign bus.read_index = idx_r;
    assign bus.out_data   = out_data_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.checksum   = checksum_r;
endmodule

// File: tb/tb_regfile_stream_reader.sv
// Directed bench for regfile_stream_reader: a queue model of the words a command
// must stream, checked every negedge, plus literal expectations per scenario.
module tb_regfile_stream_reader;
    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    regfile_stream_reader_if #(.DATA_WIDTH(8), .INDEX_WIDTH(2)) bus ();
    regfile_stream_reader #(.DATA_WIDTH(8), .INDEX_WIDTH(2)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    logic [7:0] regs [4];
    assign bus.read_data = regs[bus.read_index];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0] exp_word_q [$];
    logic [1:0] exp_idx_q  [$];
    logic [7:0] model_sum;
    bit         pending, prev_valid, prev_done, prev_accept, prev_last;
    int         done_count = 0;
    logic [7:0] log_word [8];
    logic [1:0] log_idx  [8];
    int         log_vcyc [8];
    int         log_n, valid_cnt, start_cyc, done_cyc;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [1:0] si, input logic [1:0] cnt);
        bus.start       = 1'b1;
        bus.start_index = si;
        bus.count       = cnt;
        start_cyc       = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    // Words a command must produce: file contents from start index, wrapping.
    task automatic expect_cmd(input int si, input int cnt);
        int n = (cnt == 0) ? 4 : cnt;
        exp_word_q.delete();
        exp_idx_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_word_q.push_back(regs[(si + i) % 4]);
            exp_idx_q.push_back(2'((si + i) % 4));
        end
        model_sum = 8'h00;
        pending   = 1'b1;
        log_n     = 0;
        valid_cnt = 0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check(bus.done === 1'b1, name, 32'(bus.done), 32'd1);
        done_cyc = cyc;
    endtask

    task automatic check_zero(input string tag);
        check(bus.read_index == 2'd0, {tag, "_read_index"}, 32'(bus.read_index), 32'd0);
        check(bus.out_data == 8'h00,  {tag, "_out_data"},   32'(bus.out_data),   32'd0);
        check(bus.checksum == 8'h00,  {tag, "_checksum"},   32'(bus.checksum),   32'd0);
        check(bus.out_valid == 1'b0,  {tag, "_out_valid"},  32'(bus.out_valid),  32'd0);
        check(bus.busy == 1'b0,       {tag, "_busy"},       32'(bus.busy),       32'd0);
        check(bus.done == 1'b0,       {tag, "_done"},       32'(bus.done),       32'd0);
    endtask

    // Compare process: outputs against the word queue on every falling edge.
    always @(negedge clock) begin
        if (clear) begin
            exp_word_q.delete();
            exp_idx_q.delete();
            pending     = 1'b0;
            prev_valid  = 1'b0;
            prev_done   = 1'b0;
            prev_accept = 1'b0;
            prev_last   = 1'b0;
        end else begin
            if (prev_done) check(bus.busy == 1'b0, "busy_after_done", 32'(bus.busy), 32'd0);
            if (prev_accept) check(bus.out_valid == 1'b0, "gap_after_accept", 32'(bus.out_valid), 32'd0);
            if (prev_last) check(bus.done == 1'b1, "done_after_last", 32'(bus.done), 32'd1);
            if (bus.done) begin
                check(prev_last && pending, "done_expected", {30'd0, pending, prev_last}, 32'd3);
                check(bus.checksum == model_sum, "checksum_model", 32'(bus.checksum), 32'(model_sum));
                check(bus.busy == 1'b1, "busy_in_done", 32'(bus.busy), 32'd1);
                pending = 1'b0;
                done_count++;
            end
            prev_accept = 1'b0;
            prev_last   = 1'b0;
            if (bus.out_valid) begin
                check(exp_word_q.size() != 0, "valid_expected", 32'(bus.out_valid), 32'd0);
                if (exp_word_q.size() != 0) begin
                    if (!prev_valid && log_n < 8) log_vcyc[log_n] = cyc;
                    valid_cnt++;
                    check(bus.out_data == exp_word_q[0], "out_data", 32'(bus.out_data), 32'(exp_word_q[0]));
                    check(bus.read_index == exp_idx_q[0], "read_index", 32'(bus.read_index), 32'(exp_idx_q[0]));
                    check(bus.busy == 1'b1, "busy_in_hold", 32'(bus.busy), 32'd1);
                    if (bus.out_ready) begin
                        if (log_n < 8) begin
                            log_word[log_n] = bus.out_data;
                            log_idx[log_n]  = bus.read_index;
                        end
                        log_n++;
                        model_sum = model_sum + bus.out_data;
                        void'(exp_word_q.pop_front());
                        void'(exp_idx_q.pop_front());
                        prev_accept = 1'b1;
                        prev_last   = (exp_word_q.size() == 0);
                    end
                end
            end
            prev_valid = bus.out_valid;
            prev_done  = bus.done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] basic_w [4];
    int         done_before;

    initial begin
        clear           = 1'b1;
        bus.start       = 1'b0;
        bus.start_index = 2'd0;
        bus.count       = 2'd0;
        bus.out_ready   = 1'b0;
        regs            = '{8'h11, 8'h22, 8'h33, 8'h44};
        basic_w         = '{8'h11, 8'h22, 8'h33, 8'h44};
        repeat (3) tick();
        check_zero("reset_hold");
        clear = 1'b0;

        // Basic four-word walk with the consumer always ready.
        bus.out_ready = 1'b1;
        issue(2'd0, 2'd0);
        expect_cmd(0, 0);
        wait_done("basic_done");
        check(bus.checksum == 8'hAA, "basic_checksum", 32'(bus.checksum), 32'hAA);
        check(log_n == 4, "basic_word_count", 32'(log_n), 32'd4);
        for (int i = 0; i < 4; i++)
            check(log_word[i] == basic_w[i], "basic_word", 32'(log_word[i]), 32'(basic_w[i]));
        check(log_vcyc[0] - start_cyc == 2, "basic_latency", 32'(log_vcyc[0] - start_cyc), 32'd2);
        for (int i = 1; i < 4; i++)
            check(log_vcyc[i] - log_vcyc[i-1] == 2, "basic_spacing", 32'(log_vcyc[i] - log_vcyc[i-1]), 32'd2);
        check(done_cyc == log_vcyc[3] + 1, "basic_done_cycle", 32'(done_cyc), 32'(log_vcyc[3] + 1));
        tick();

        // Wrap from index 3 to index 0.
        tick();
        issue(2'd3, 2'd2);
        expect_cmd(3, 2);
        wait_done("wrap_done");
        check(bus.checksum == 8'h55, "wrap_checksum", 32'(bus.checksum), 32'h55);
        check(log_word[0] == 8'h44 && log_word[1] == 8'h11, "wrap_words",
              {16'd0, log_word[0], log_word[1]}, 32'h4411);
        check(log_idx[0] == 2'd3 && log_idx[1] == 2'd0, "wrap_indices",
              {28'd0, log_idx[0], log_idx[1]}, 32'hC);
        tick();

        // Backpressure: consumer stalls five cycles.
        tick();
        bus.out_ready = 1'b0;
        issue(2'd1, 2'd1);
        expect_cmd(1, 1);
        tick();
        repeat (5) tick();
        bus.out_ready = 1'b1;
        wait_done("bp_done");
        check(valid_cnt == 6, "bp_valid_cycles", 32'(valid_cnt), 32'd6);
        check(log_word[0] == 8'h22, "bp_word", 32'(log_word[0]), 32'h22);
        check(bus.checksum == 8'h22, "bp_checksum", 32'(bus.checksum), 32'h22);
        check(done_cyc == start_cyc + 8, "bp_done_cycle", 32'(done_cyc - start_cyc), 32'd8);
        tick();

        // Overflowing sum, start while busy, start coincident with done.
        tick();
        regs = '{8'hFF, 8'h02, 8'h80, 8'h80};
        issue(2'd0, 2'd0);
        expect_cmd(0, 0);
        tick();
        bus.start       = 1'b1;
        bus.start_index = 2'd2;
        bus.count       = 2'd1;
        tick();
        bus.start = 1'b0;
        wait_done("ovf_done");
        check(bus.checksum == 8'h01, "ovf_checksum", 32'(bus.checksum), 32'h01);
        check(log_n == 4, "ovf_word_count", 32'(log_n), 32'd4);
        bus.start       = 1'b1;
        bus.start_index = 2'd1;
        bus.count       = 2'd1;
        tick();
        bus.start = 1'b0;
        check(bus.busy == 1'b0, "ovf_busy_drop", 32'(bus.busy), 32'd0);
        repeat (4) tick();
        check(bus.busy == 1'b0 && bus.out_valid == 1'b0, "done_start_ignored",
              {30'd0, bus.busy, bus.out_valid}, 32'd0);
        check(bus.checksum == 8'h01, "checksum_holds", 32'(bus.checksum), 32'h01);

        // Asynchronous clear in the middle of HOLD.
        regs          = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.out_ready = 1'b0;
        issue(2'd0, 2'd0);
        expect_cmd(0, 0);
        tick();
        check(bus.out_valid == 1'b1, "pre_reset_valid", 32'(bus.out_valid), 32'd1);
        #2 clear = 1'b1;
        #1 check_zero("reset_async");
        done_before = done_count;
        tick();
        clear         = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) tick();
        check(done_count == done_before, "reset_no_done", 32'(done_count), 32'(done_before));
        check(bus.busy == 1'b0, "reset_idle", 32'(bus.busy), 32'd0);

        // Live write to index 2 during the first FETCH.
        issue(2'd0, 2'd0);
        @(negedge clock);
        regs[2] = 8'h5A;
        expect_cmd(0, 0);
        wait_done("live_done");
        check(log_word[2] == 8'h5A, "live_word", 32'(log_word[2]), 32'h5A);
        check(bus.checksum == 8'hD1, "live_checksum", 32'(bus.checksum), 32'hD1);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
